// File: rtl/ringmeas_pkg.sv
// Shared types and defaults for the ring oscillator frequency meter.
// Holds the measurement FSM state encoding, default parameter values and a
// saturating increment helper used by the edge accumulator.
package ringmeas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } ringmeas_state_t;

  localparam int DEF_NCH         = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GATE_W      = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Increment v by one, clamping at max_v (callers pass widths up to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/ringmeas_sync.sv
// Single-bit multi-flop synchroniser bringing one ring output into clk.
// Latency: STAGES clk cycles from a stable input to q.
// No backpressure; samples every cycle, synchronous active-high reset clears all stages.
module ringmeas_sync
  import ringmeas_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  // Shift the asynchronous input one stage deeper each cycle.
  always_comb begin
    ff_d = {ff_q[STAGES-2:0], d};
  end

  // Synchroniser flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) ff_q <= '0;
    else     ff_q <= ff_d;
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Multi-channel ring oscillator frequency meter: counts rising edges of the selected
// synchronised ring over gate_len clk cycles; done pulses gate_len+2 cycles after start.
// start is only sampled in IDLE and never queued; RINGMEAS_CONTINUOUS_EN adds a cont input for back-to-back windows.
module ring_osc_freq_meter
  import ringmeas_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    osc_in,
  input  logic              start,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [GATE_W-1:0] gate_len,
`ifdef RINGMEAS_CONTINUOUS_EN
  input  logic              cont,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam logic [31:0] CNT_MAX32 = 32'((64'd1 << CNT_W) - 64'd1);

  logic [NCH-1:0]    sync_vec;
  logic              sel_sync;
  logic              cont_en;
  logic              rise;

  ringmeas_state_t   state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [GATE_W-1:0] win_q, win_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic              prev_q, prev_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

`ifdef RINGMEAS_CONTINUOUS_EN
  assign cont_en = cont;
`else
  assign cont_en = 1'b0;
`endif

  // All channels are synchronised in parallel so a channel switch needs no flush.
  for (genvar g = 0; g < NCH; g++) begin : g_sync
    ringmeas_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (osc_in[g]),
      .q   (sync_vec[g])
    );
  end

  // Select the latched channel after synchronisation.
  always_comb begin
    sel_sync = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == SEL_W'(i)) sel_sync = sync_vec[i];
    end
  end

  assign rise = sel_sync & ~prev_q;

  // Measurement FSM: accept start, settle edge detector, count the window, publish.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gate_d     = gate_q;
    win_d      = win_q;
    acc_d      = acc_q;
    ovf_flag_d = ovf_flag_q;
    prev_d     = prev_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (32'(ch_sel) < NCH) && (gate_len != '0)) begin
          sel_d   = ch_sel;
          gate_d  = gate_len;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // An edge landing here only primes prev; it is not counted.
        prev_d     = sel_sync;
        win_d      = gate_q;
        acc_d      = '0;
        ovf_flag_d = 1'b0;
        state_d    = ST_COUNT;
      end
      ST_COUNT: begin
        prev_d = sel_sync;
        if (rise) begin
          if (&acc_q) ovf_flag_d = 1'b1;
          acc_d = CNT_W'(sat_inc(32'(acc_q), CNT_MAX32));
        end
        win_d = win_q - 1'b1;
        if (win_q == GATE_W'(1)) begin
          // Publish at the same edge that enters DONE so done and count align.
          count_d    = acc_d;
          overflow_d = ovf_flag_d;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cont_en) begin
          state_d = ST_SETTLE;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any window without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      gate_q     <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      ovf_flag_q <= 1'b0;
      prev_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gate_q     <= gate_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      ovf_flag_q <= ovf_flag_d;
      prev_q     <= prev_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: a default 4-channel instance and a 3-channel,
// 4-bit-count instance driven by synthetic ring outputs. Build with
// RINGMEAS_CONTINUOUS_EN defined to also exercise continuous mode.
module tb_ring_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  wire  [3:0]  osc;
  int          half_ns [4] = '{0, 0, 0, 0};

  logic        start_a, start_b;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] gate_a, gate_b;
  logic        cont_a;
  logic        busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Synthetic ring outputs: half period in ns, 0 means held low. Edges sit 3 ns past a 10 ns grid.
  for (genvar g = 0; g < 4; g++) begin : g_osc
    logic o;
    initial begin
      o = 1'b0;
      #3;
      forever begin
        if (half_ns[g] == 0) begin
          o = 1'b0;
          #10;
        end else begin
          #(half_ns[g]);
          o = ~o;
        end
      end
    end
    assign osc[g] = o;
  end

  ring_osc_freq_meter dut_a (
    .clk      (clk),
    .rst      (rst),
    .osc_in   (osc),
    .start    (start_a),
    .ch_sel   (sel_a),
    .gate_len (gate_a),
`ifdef RINGMEAS_CONTINUOUS_EN
    .cont     (cont_a),
`endif
    .busy     (busy_a),
    .done     (done_a),
    .count    (count_a),
    .overflow (ovf_a)
  );

  ring_osc_freq_meter #(.NCH(3), .CNT_W(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .osc_in   (osc[2:0]),
    .start    (start_b),
    .ch_sel   (sel_b),
    .gate_len (gate_b),
`ifdef RINGMEAS_CONTINUOUS_EN
    .cont     (1'b0),
`endif
    .busy     (busy_b),
    .done     (done_b),
    .count    (count_b),
    .overflow (ovf_b)
  );

  // Launch one measurement and wait for done; lat counts cycles after the accepting edge.
  task automatic measure(input bit b, input logic [1:0] ch, input logic [15:0] gl,
                         output int cnt, output bit ovf, output int lat,
                         output int bcyc, output bit to);
    @(negedge clk);
    if (b) begin start_b = 1'b1; sel_b = ch; gate_b = gl; end
    else   begin start_a = 1'b1; sel_a = ch; gate_a = gl; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1; bcyc = 0; to = 1'b1; cnt = 0; ovf = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (b ? busy_b : busy_a) bcyc++;
      if (b ? done_b : done_a) begin
        to  = 1'b0;
        cnt = b ? int'(count_b) : int'(count_a);
        ovf = b ? ovf_b : ovf_a;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
    n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
  endtask

  task automatic test_basic;
    int cnt, lat, bcyc; bit ovf, to;
    half_ns = '{50, 0, 0, 0};
    repeat (20) @(negedge clk);
    measure(1'b0, 2'd0, 16'd100, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: no done, expected done"); end
    n_checks++; if (lat != 102) begin n_fail++; $display("FAIL basic_latency: got %0d expected 102", lat); end
    n_checks++; if (bcyc != 102) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 102", bcyc); end
    n_checks++; if (cnt < 9 || cnt > 11) begin n_fail++; $display("FAIL basic_count: got %0d expected 10+-1", cnt); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
    @(negedge clk);
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy_a); end
    n_checks++; if (cnt < 9 || cnt > 11 || count_a !== 16'(cnt)) begin n_fail++; $display("FAIL basic_count_hold: got %0d expected 10+-1", count_a); end
  endtask

  task automatic test_reset_mid;
    int cnt, lat, bcyc; bit ovf, to, seen;
    @(negedge clk);
    start_a = 1'b1; sel_a = 2'd0; gate_a = 16'd100;
    @(negedge clk);
    start_a = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
    n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", count_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b expected 0", ovf_a); end
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (done_a === 1'b1 || busy_a === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_no_done: got activity expected none"); end
    measure(1'b0, 2'd0, 16'd100, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || lat != 102) begin n_fail++; $display("FAIL rstmid_restart_latency: got %0d (timeout %b) expected 102", lat, to); end
    n_checks++; if (cnt < 9 || cnt > 11) begin n_fail++; $display("FAIL rstmid_restart_count: got %0d expected 10+-1", cnt); end
  endtask

  task automatic test_isolation;
    int cnt, lat, bcyc; bit ovf, to;
    half_ns = '{0, 100, 20, 0};
    repeat (20) @(negedge clk);
    measure(1'b0, 2'd2, 16'd200, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || lat != 202) begin n_fail++; $display("FAIL iso_ch2_latency: got %0d (timeout %b) expected 202", lat, to); end
    n_checks++; if (cnt < 49 || cnt > 51) begin n_fail++; $display("FAIL iso_ch2_count: got %0d expected 50+-1", cnt); end
    measure(1'b0, 2'd3, 16'd200, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || cnt != 0) begin n_fail++; $display("FAIL iso_ch3_count: got %0d (timeout %b) expected 0", cnt, to); end
    measure(1'b0, 2'd1, 16'd200, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || cnt < 9 || cnt > 11) begin n_fail++; $display("FAIL iso_ch1_count: got %0d (timeout %b) expected 10+-1", cnt, to); end
  endtask

  task automatic test_saturation;
    int cnt, lat, bcyc; bit ovf, to;
    measure(1'b1, 2'd2, 16'd100, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || lat != 102) begin n_fail++; $display("FAIL sat_latency: got %0d (timeout %b) expected 102", lat, to); end
    n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", cnt); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", ovf); end
    measure(1'b1, 2'd2, 16'd20, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || cnt < 4 || cnt > 6) begin n_fail++; $display("FAIL sat_follow_count: got %0d (timeout %b) expected 5+-1", cnt, to); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_follow_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_rejection;
    bit seen;
    @(negedge clk);
    start_a = 1'b1; sel_a = 2'd2; gate_a = 16'd0;
    @(negedge clk);
    start_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy_a === 1'b1 || done_a === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL reject_gate0: got activity expected none"); end
    start_b = 1'b1; sel_b = 2'd3; gate_b = 16'd10;
    @(negedge clk);
    start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy_b === 1'b1 || done_b === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL reject_chsel_nch: got activity expected none"); end
  endtask

  task automatic test_busy_start;
    int lat, dones; bit to;
    half_ns = '{50, 0, 0, 0};
    repeat (20) @(negedge clk);
    start_a = 1'b1; sel_a = 2'd0; gate_a = 16'd40;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (lat == 10) begin start_a = 1'b1; sel_a = 2'd3; gate_a = 16'd5; end
      else if (lat == 11) start_a = 1'b0;
      if (done_a === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
      lat++;
    end
    n_checks++; if (to || lat != 42) begin n_fail++; $display("FAIL busy_start_latency: got %0d (timeout %b) expected 42", lat, to); end
    n_checks++; if (count_a < 16'd3 || count_a > 16'd5) begin n_fail++; $display("FAIL busy_start_count: got %0d expected 4+-1", count_a); end
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL busy_start_second_done: got %0d expected 0", dones); end
  endtask

`ifdef RINGMEAS_CONTINUOUS_EN
  task automatic test_continuous;
    int cnt, lat, bcyc, gap, dones; bit ovf, to;
    half_ns = '{50, 0, 0, 0};
    repeat (20) @(negedge clk);
    cont_a = 1'b1;
    measure(1'b0, 2'd0, 16'd50, cnt, ovf, lat, bcyc, to);
    n_checks++; if (to || lat != 52) begin n_fail++; $display("FAIL cont_first_latency: got %0d (timeout %b) expected 52", lat, to); end
    n_checks++; if (cnt < 4 || cnt > 6) begin n_fail++; $display("FAIL cont_first_count: got %0d expected 5+-1", cnt); end
    gap = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      gap++;
      if (done_a === 1'b1) break;
    end
    n_checks++; if (gap != 52) begin n_fail++; $display("FAIL cont_period: got %0d expected 52", gap); end
    n_checks++; if (count_a < 16'd4 || count_a > 16'd6) begin n_fail++; $display("FAIL cont_second_count: got %0d expected 5+-1", count_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL cont_busy: got %b expected 1", busy_a); end
    @(negedge clk);
    cont_a = 1'b0;
    gap = 1;
    for (int i = 0; i < 200; i++) begin
      if (done_a === 1'b1) break;
      @(negedge clk);
      gap++;
    end
    n_checks++; if (gap != 52) begin n_fail++; $display("FAIL cont_final_period: got %0d expected 52", gap); end
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL cont_final_busy: got %b expected 0", busy_a); end
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_a === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL cont_extra_done: got %0d expected 0", dones); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    sel_a = 2'd0; sel_b = 2'd0;
    gate_a = 16'd0; gate_b = 16'd0;
    cont_a = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_isolation();
    test_saturation();
    test_rejection();
    test_busy_start();
`ifdef RINGMEAS_CONTINUOUS_EN
    test_continuous();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
- Multi-channel frequency meter for the on-die ring oscillators.
- Selects one of NCH pre-divided ring outputs and synchronises it into `clk`.
- Counts its rising edges over a programmable gate window of `clk` cycles and reports the count with a start/busy/done handshake.
- Replaces ad-hoc per-ring divider taps with one measured, readable result, so ring frequency = count × divider ratio × f_clk / gate_len.

Parameters:
- NCH, 4, number of oscillator channels (≥1).
- CNT_W, 16, width of edge count result.
- GATE_W, 16, width of gate-length input.
- SYNC_STAGES, 2, flip-flops per channel synchroniser (≥2).
- SEL_W, $clog2(NCH) (min 1), derived width of ch_sel; localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic in this domain.
- rst  input  1  synchronous reset, active-high.
- osc_in  input  NCH  pre-divided ring outputs; asynchronous to clk; each must be < f_clk/2.
- start  input  1  request measurement; sampled in IDLE only.
- ch_sel  input  SEL_W  channel to measure; latched on accepted start.
- gate_len  input  GATE_W  window length in clk cycles; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when count/overflow are updated.
- count  output  CNT_W  rising edges seen in last window; held until next done.
- overflow  output  1  last window saturated count; held until next done.
- cont  input  1  continuous mode request (present only with RINGMEAS_CONTINUOUS_EN).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst=1 at a clk edge): state=IDLE, busy=0, done=0, count=0, overflow=0, synchroniser and edge registers 0. Reset mid-operation aborts the window with no done pulse and outputs cleared.
- Synchronisers: every channel is synchronised in parallel with SYNC_STAGES FFs, and the mux follows them. Switching channels therefore needs no flush.
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - start=1 with ch_sel<NCH and gate_len≠0 is accepted. ch_sel and gate_len are latched, then → SETTLE.
  - Otherwise start is ignored and the block stays in IDLE with no done.
- SETTLE (1 cycle): edge register prev ← selected synced value; window counter ← latched gate_len; internal edge accumulator ← 0 → COUNT.
- COUNT (exactly gate_len cycles):
  - Each cycle, if synced=1 and prev=0, the accumulator increments; prev updates every cycle.
  - The accumulator saturates at 2^CNT_W−1, and any further edge sets the overflow flag.
  - Leaves COUNT when the window counter reaches 0 → DONE.
- DONE (1 cycle): count ← accumulator, overflow ← flag, done=1, then → IDLE.
- busy=1 in SETTLE, COUNT and DONE.
- Latency: start accepted at edge T; SETTLE is cycle T+1; COUNT is T+2..T+1+gate_len; done=1 in cycle T+2+gate_len.
- start while busy is ignored, and no request is queued.
- An edge arriving in the SETTLE cycle is not counted. Resolution is therefore ±1 edge.
- Changing ch_sel or gate_len while busy has no effect on the current window.

Optional Feature:
- RINGMEAS_CONTINUOUS_EN defined:
  - Adds the cont input.
  - In DONE with cont=1, the FSM goes to SETTLE instead of IDLE and reuses the latched ch_sel and gate_len. busy stays 1 and done pulses once per window.
  - With cont=0 in DONE, the FSM returns to IDLE.
- Undefined: no cont port; every measurement needs its own start.

Decomposition:
- Shared package ringmeas_pkg holds:
  - the state enum (IDLE, SETTLE, COUNT, DONE);
  - the default parameter constants;
  - a saturating-increment function.
- One sub-module: ringmeas_sync, a single-bit SYNC_STAGES-deep synchroniser with synchronous reset, instantiated NCH times.
- The FSM, window counter, mux and accumulator stay in the top module.

Test Plan:
- Ch0 toggles every 5 clk (period 10); start with ch_sel=0, gate_len=100 → done in cycle T+102, count=10±1, overflow=0, busy high for exactly 102 cycles.
- Channel isolation: ch1 period 20, ch2 period 4, others static; measure ch2 with gate_len=200 → count 50±1. Measure ch3 → count 0.
- Saturation with CNT_W=4: period 4, gate_len=100 → count=15, overflow=1. A following measurement with gate_len=20 → count=5±1, overflow=0.
- Rejection:
  - start with gate_len=0 → no busy, no done.
  - start with ch_sel=NCH (NCH not power of 2) → ignored.
  - start pulsed during COUNT → no second done.
- Reset: assert rst at COUNT cycle 30 → next cycle busy=0, count=0, overflow=0, no done. A new start then completes normally.
- With RINGMEAS_CONTINUOUS_EN: cont=1, gate_len=50, period 10 → done every 52 cycles with count 5±1. Drop cont → one final done, then busy=0.
